// File: rtl/shift_arbiter_pkg.sv
// Shared constants for the shift arbiter: operand widths, shift-type codes
// and the result-register state encoding.
package shift_arbiter_pkg;

  localparam int DATA_W = 32;
  localparam int AMT_W  = 5;

  localparam logic [1:0] SHIFT_SLL = 2'b00;
  localparam logic [1:0] SHIFT_SRL = 2'b01;
  localparam logic [1:0] SHIFT_SRA = 2'b11;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/shifter_32.sv
// Combinational 32-bit barrel shifter. Code 2'b10 takes the default arm
// and behaves as a logical left shift.
module shifter_32
  import shift_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [AMT_W-1:0]  b,
  input  logic [1:0]        c,
  output logic [DATA_W-1:0] z
);

  logic signed [DATA_W-1:0] a_s;

  assign a_s = a;

  always_comb begin
    z = a << b;
    case (c)
      SHIFT_SRL: z = a >> b;
      SHIFT_SRA: z = $unsigned(a_s >>> b);
      default:   z = a << b;
    endcase
  end

endmodule

// File: rtl/shift_arbiter.sv
// Two requesters share one shifter; a round-robin grant feeds a single
// result register that can drain and refill in the same cycle.
module shift_arbiter
  import shift_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [4:0]  req0_b,
  input  logic [1:0]  req0_c,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [4:0]  req1_b,
  input  logic [1:0]  req1_c,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_z,
  output logic        rsp_id
);

  state_t              state, state_next;
  logic                ptr, ptr_next;
  logic                free;
  logic                grant0, grant1, grant;
  logic [DATA_W-1:0]   sh_a, sh_z;
  logic [AMT_W-1:0]    sh_b;
  logic [1:0]          sh_c;
  logic [DATA_W-1:0]   z_p1;
  logic                id_p1;

  // Grant stage: pointer only breaks ties, operands never influence ready.
  assign free   = (state == EMPTY) || rsp_ready;
  assign grant0 = !rst && free && req0_valid && (!req1_valid || !ptr);
  assign grant1 = !rst && free && req1_valid && (!req0_valid || ptr);
  assign grant  = grant0 || grant1;

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  assign sh_a = grant1 ? req1_a : req0_a;
  assign sh_b = grant1 ? req1_b : req0_b;
  assign sh_c = grant1 ? req1_c : req0_c;

  shifter_32 u_shifter (
    .a (sh_a),
    .b (sh_b),
    .c (sh_c),
    .z (sh_z)
  );

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    if (grant) ptr_next = ~grant1;
    case (state)
      EMPTY:   if (grant) state_next = FULL;
      FULL:    if (rsp_ready && !grant) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  // Result stage: a pending result is discarded on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      ptr   <= 1'b0;
      z_p1  <= '0;
      id_p1 <= 1'b0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
      if (grant) begin
        z_p1  <= sh_z;
        id_p1 <= grant1;
      end
    end
  end

  assign rsp_valid = (state == FULL);
  assign rsp_z     = z_p1;
  assign rsp_id    = id_p1;

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: transaction-level reference model checked every
// cycle, directed literal scenarios, then randomized traffic with resets.
module tb_shift_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready;
  logic [31:0] req0_a;
  logic [4:0]  req0_b;
  logic [1:0]  req0_c;
  logic        req1_valid, req1_ready;
  logic [31:0] req1_a;
  logic [4:0]  req1_b;
  logic [1:0]  req1_c;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_z;
  logic        rsp_id;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  logic        m_valid = 1'b0;
  logic [31:0] m_z = '0;
  logic        m_id = 1'b0;
  logic        m_ptr = 1'b0;

  shift_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_c     (req0_c),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_c     (req1_c),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_z      (rsp_z),
    .rsp_id     (rsp_id)
  );

  always #5 clk = ~clk;

  // Shift defined arithmetically: multiply/divide by powers of two.
  function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [4:0] b,
                                            input logic [1:0] c);
    logic [31:0] p;
    p = 32'd1 << b;
    case (c)
      2'b01:   return a / p;
      2'b11:   return a[31] ? ~((~a) / p) : a / p;
      default: return a * p;
    endcase
  endfunction

  function automatic void model_grant(output logic g0, output logic g1);
    logic free;
    free = !m_valid || rsp_ready;
    g0 = 1'b0;
    g1 = 1'b0;
    if (!rst && free) begin
      if (req0_valid && req1_valid) begin
        g0 = !m_ptr;
        g1 = m_ptr;
      end else begin
        g0 = req0_valid;
        g1 = req1_valid;
      end
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    logic g0, g1;
    model_grant(g0, g1);
    if (rst) begin
      m_valid = 1'b0;
      m_z     = '0;
      m_id    = 1'b0;
      m_ptr   = 1'b0;
    end else if (g0 || g1) begin
      m_valid = 1'b1;
      m_id    = g1;
      m_z     = g1 ? ref_shift(req1_a, req1_b, req1_c) : ref_shift(req0_a, req0_b, req0_c);
      m_ptr   = g0;
    end else if (rsp_ready) begin
      m_valid = 1'b0;
    end
  end

  always @(negedge clk) begin
    logic e0, e1;
    if (chk_en) begin
      model_grant(e0, e1);
      chk("model_rsp_valid", 32'(rsp_valid), 32'(m_valid));
      if (m_valid) begin
        chk("model_rsp_z", rsp_z, m_z);
        chk("model_rsp_id", 32'(rsp_id), 32'(m_id));
      end
      chk("model_req0_ready", 32'(req0_ready), 32'(e0));
      chk("model_req1_ready", 32'(req1_ready), 32'(e1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic v, input logic [31:0] a, input logic [4:0] b, input logic [1:0] c);
    req0_valid = v; req0_a = a; req0_b = b; req0_c = c;
  endtask

  task automatic set1(input logic v, input logic [31:0] a, input logic [4:0] b, input logic [1:0] c);
    req1_valid = v; req1_a = a; req1_b = b; req1_c = c;
  endtask

  logic [31:0] bnd_a [3] = '{32'hDEADBEEF, 32'hFFFFFFFF, 32'hFFFFFFFF};
  logic [4:0]  bnd_b [3] = '{5'd0, 5'd31, 5'd31};
  logic [1:0]  bnd_c [3] = '{2'b00, 2'b01, 2'b11};
  logic [31:0] bnd_z [3] = '{32'hDEADBEEF, 32'h00000001, 32'hFFFFFFFF};

  initial begin
    logic [31:0] sa;
    logic [4:0]  sb;
    logic [1:0]  sc;
    logic [1:0]  codes [3] = '{2'b00, 2'b01, 2'b11};
    rst = 1'b1;
    rsp_ready = 1'b0;
    set0(1'b0, '0, '0, '0);
    set1(1'b0, '0, '0, '0);
    tick();
    tick();
    chk_en = 1'b1;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_z", rsp_z, 32'd0);
    chk("reset_rsp_id", 32'(rsp_id), 32'd0);
    set0(1'b1, 32'h1, 5'd1, 2'b00);
    #1;
    chk("reset_req0_ready", 32'(req0_ready), 32'd0);

    // Single request
    rst = 1'b0;
    rsp_ready = 1'b1;
    set0(1'b1, 32'hA5A5A5A5, 5'd4, 2'b00);
    #1;
    chk("single_req0_ready", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0;
    chk("single_valid", 32'(rsp_valid), 32'd1);
    chk("single_z", rsp_z, 32'h5A5A5A50);
    chk("single_id", 32'(rsp_id), 32'd0);
    tick();
    chk("single_drained", 32'(rsp_valid), 32'd0);

    // Contention from a freshly reset pointer
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set0(1'b1, 32'hF0F0F0F0, 5'd4, 2'b01);
    set1(1'b1, 32'h80000000, 5'd8, 2'b11);
    tick();
    chk("cont_first_z", rsp_z, 32'h0F0F0F0F);
    chk("cont_first_id", 32'(rsp_id), 32'd0);
    req0_valid = 1'b0;
    tick();
    chk("cont_second_z", rsp_z, 32'hFF800000);
    chk("cont_second_id", 32'(rsp_id), 32'd1);
    req0_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("cont_alternate_id", 32'(rsp_id), 32'(i % 2));
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();

    // Back-pressure
    rsp_ready = 1'b0;
    set0(1'b1, 32'h12345678, 5'd16, 2'b01);
    tick();
    req0_valid = 1'b0;
    set1(1'b1, 32'h00000001, 5'd1, 2'b00);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_z", rsp_z, 32'h00001234);
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_req0_ready", 32'(req0_ready), 32'd0);
      chk("bp_req1_ready", 32'(req1_ready), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_refill_ready", 32'(req1_ready), 32'd1);
    tick();
    req1_valid = 1'b0;
    chk("bp_refill_z", rsp_z, 32'h00000002);
    chk("bp_refill_id", 32'(rsp_id), 32'd1);

    // Boundary shifts
    for (int i = 0; i < 3; i++) begin
      set0(1'b1, bnd_a[i], bnd_b[i], bnd_c[i]);
      tick();
      chk("boundary_z", rsp_z, bnd_z[i]);
    end
    req0_valid = 1'b0;
    tick();

    // Reset mid-operation: last grant went to req0, so pointer favours req1
    rsp_ready = 1'b0;
    set0(1'b1, 32'h00000010, 5'd2, 2'b00);
    tick();
    req0_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("midrst_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_z", rsp_z, 32'd0);
    rst = 1'b0;
    rsp_ready = 1'b1;
    set0(1'b1, 32'h00000003, 5'd1, 2'b00);
    set1(1'b1, 32'h00000004, 5'd1, 2'b00);
    tick();
    chk("midrst_first_id", 32'(rsp_id), 32'd0);
    chk("midrst_first_z", rsp_z, 32'h00000006);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();

    // Streaming: eight back-to-back req1 operations
    for (int i = 0; i < 8; i++) begin
      sa = (32'h80000000 >> i) | 32'(i);
      sb = 5'(i * 3);
      sc = i[0] ? 2'b11 : 2'b01;
      set1(1'b1, sa, sb, sc);
      tick();
      chk("stream_valid", 32'(rsp_valid), 32'd1);
      chk("stream_z", rsp_z, ref_shift(sa, sb, sc));
      chk("stream_id", 32'(rsp_id), 32'd1);
    end
    req1_valid = 1'b0;
    tick();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      set0(1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 31)),
           codes[$urandom_range(0, 2)]);
      set1(1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 31)),
           codes[$urandom_range(0, 2)]);
      tick();
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
